// File: rtl/mlp_conv_pkg.sv
// Shared types and helpers for the mlp_conv datapath: lane limit, result-output FSM states,
// and the accumulator-to-result saturation function.
package mlp_conv_pkg;

    localparam int MAX_LANES = 5;
    localparam int SAT_W     = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } res_out_state_t;

    // acc holds acc_w valid bits (zero-extended by the caller); result is {clamped, value}
    function automatic logic [SAT_W:0] sat_acc(
        input logic [SAT_W-1:0] acc,
        input int               acc_w,
        input int               out_w
    );
        logic signed [SAT_W-1:0] ext;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        for (int i = 0; i < SAT_W; i++) begin
            ext[i] = (i < acc_w) ? acc[i] : acc[acc_w-1];
        end
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (ext > max_v) begin
            return {1'b1, max_v};
        end else if (ext < min_v) begin
            return {1'b1, min_v};
        end else begin
            return {1'b0, ext};
        end
    endfunction

endpackage

// File: rtl/result_out_ctrl_fifo.sv
// Synchronous single-clock FIFO; writes while full and reads while empty are ignored.
// rst_n_i is a synchronous active-low reset that empties the FIFO.
module result_out_ctrl_fifo #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [FIFO_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [FIFO_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  wr_s;
    logic                  rd_s;

    assign empty_o   = (count_q == CW'(0));
    assign full_o    = (count_q == CW'(FIFO_DEPTH));
    assign wr_s      = wr_en_i && !full_o;
    assign rd_s      = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage array; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? AW'(0) : wr_ptr_q + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? AW'(0) : rd_ptr_q + AW'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/result_out_ctrl.sv
// Result output controller: accepts a set of accumulator lanes, saturates and serialises them into
// an output FIFO. Defining RESULT_OUT_RELU_EN zeroes negative lanes before saturation.
module result_out_ctrl
    import mlp_conv_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 32,
    parameter int ACC_WIDTH    = 40,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    CLEAR_FIFO,
    input  logic [2:0]              PARAM_LANES,
    input  logic                    RES_VALID,
    output logic                    RES_READY,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_0,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_1,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_2,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_3,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_4,
    input  logic                    FIFO_RD_CMD,
    output logic [OUTPUT_WIDTH-1:0] FIFO_RD_DATA,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic                    BUSY,
    output logic                    SAT_FLAG
);

    res_out_state_t         state_q, state_d;
    logic [2:0]             lane_idx_q, lane_idx_d;
    logic [2:0]             n_q, n_d;
    logic [ACC_WIDTH-1:0]   hold_q [MAX_LANES];
    logic [ACC_WIDTH-1:0]   hold_d [MAX_LANES];
    logic                   sat_flag_q, sat_flag_d;
    logic                   clear_fifo_q;
    logic                   clr_s;
    logic                   fifo_rst_n_s;
    logic                   fifo_wr_s;
    logic                   fifo_full_s;
    logic [2:0]             n_eff_s;
    logic [ACC_WIDTH-1:0]   lane_s;
    logic [SAT_W:0]         sat_s;
    logic                   sat_unused_s;

    assign clr_s        = CLEAR_FIFO && !clear_fifo_q;
    assign fifo_rst_n_s = RESETN && !clr_s;
    assign RES_READY    = (state_q == IDLE) && !clr_s;
    assign BUSY         = (state_q == DRAIN);
    assign SAT_FLAG     = sat_flag_q;
    assign FIFO_FULL    = fifo_full_s;
    assign sat_unused_s = ^sat_s[SAT_W-1:OUTPUT_WIDTH];

    // Effective lane count: 0 means one lane, anything above the array width is clipped
    always_comb begin
        case (PARAM_LANES)
            3'd0:       n_eff_s = 3'd1;
            3'd6, 3'd7: n_eff_s = 3'(MAX_LANES);
            default:    n_eff_s = PARAM_LANES;
        endcase
    end

    // Current lane, optionally rectified, then clamped to the output width
    always_comb begin
`ifdef RESULT_OUT_RELU_EN
        lane_s = hold_q[lane_idx_q][ACC_WIDTH-1] ? '0 : hold_q[lane_idx_q];
`else
        lane_s = hold_q[lane_idx_q];
`endif
        sat_s = sat_acc(SAT_W'(lane_s), ACC_WIDTH, OUTPUT_WIDTH);
    end

    // Accept / drain sequencing; a clear pulse overrides everything
    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        n_d        = n_q;
        hold_d     = hold_q;
        sat_flag_d = sat_flag_q;
        fifo_wr_s  = 1'b0;
        if (clr_s) begin
            state_d    = IDLE;
            lane_idx_d = 3'd0;
            sat_flag_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (RES_VALID) begin
                        hold_d[0]  = RES_DATA_0;
                        hold_d[1]  = RES_DATA_1;
                        hold_d[2]  = RES_DATA_2;
                        hold_d[3]  = RES_DATA_3;
                        hold_d[4]  = RES_DATA_4;
                        n_d        = n_eff_s;
                        lane_idx_d = 3'd0;
                        state_d    = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (!fifo_full_s) begin
                        fifo_wr_s  = 1'b1;
                        sat_flag_d = sat_flag_q | sat_s[SAT_W];
                        if (lane_idx_q == (n_q - 3'd1)) begin
                            lane_idx_d = 3'd0;
                            state_d    = IDLE;
                        end else begin
                            lane_idx_d = lane_idx_q + 3'd1;
                        end
                    end else begin
                        lane_idx_d = lane_idx_q;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    lane_idx_d = 3'd0;
                end
            endcase
        end
    end

    // State, hold registers and edge-detect history
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            lane_idx_q   <= 3'd0;
            n_q          <= 3'd1;
            sat_flag_q   <= 1'b0;
            clear_fifo_q <= 1'b0;
            for (int i = 0; i < MAX_LANES; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            n_q          <= n_d;
            sat_flag_q   <= sat_flag_d;
            clear_fifo_q <= CLEAR_FIFO;
            hold_q       <= hold_d;
        end
    end

    result_out_ctrl_fifo #(
        .FIFO_WIDTH (OUTPUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) fifo_inst (
        .clk_i     (CLK),
        .rst_n_i   (fifo_rst_n_s),
        .wr_en_i   (fifo_wr_s),
        .wr_data_i (sat_s[OUTPUT_WIDTH-1:0]),
        .rd_en_i   (FIFO_RD_CMD),
        .rd_data_o (FIFO_RD_DATA),
        .empty_o   (FIFO_EMPTY),
        .full_o    (fifo_full_s)
    );

endmodule

// File: tb/tb_result_out_ctrl.sv
// Self-checking bench for result_out_ctrl: a queue-based model checked every cycle plus
// hand-computed literal expectations. Honours RESULT_OUT_RELU_EN like the design.
module tb_result_out_ctrl;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        CLEAR_FIFO = 1'b0;
    logic [2:0]  PARAM_LANES = 3'd5;
    logic        RES_VALID = 1'b0;
    logic        RES_READY;
    logic [39:0] RES_DATA_0 = 40'd0;
    logic [39:0] RES_DATA_1 = 40'd0;
    logic [39:0] RES_DATA_2 = 40'd0;
    logic [39:0] RES_DATA_3 = 40'd0;
    logic [39:0] RES_DATA_4 = 40'd0;
    logic        FIFO_RD_CMD = 1'b0;
    logic [31:0] FIFO_RD_DATA;
    logic        FIFO_EMPTY;
    logic        FIFO_FULL;
    logic        BUSY;
    logic        SAT_FLAG;

    int checks = 0;
    int errors = 0;

    result_out_ctrl #(.OUTPUT_WIDTH(32), .ACC_WIDTH(40), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESETN(RESETN), .CLEAR_FIFO(CLEAR_FIFO), .PARAM_LANES(PARAM_LANES),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA_0(RES_DATA_0), .RES_DATA_1(RES_DATA_1), .RES_DATA_2(RES_DATA_2),
        .RES_DATA_3(RES_DATA_3), .RES_DATA_4(RES_DATA_4),
        .FIFO_RD_CMD(FIFO_RD_CMD), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_FULL(FIFO_FULL), .BUSY(BUSY), .SAT_FLAG(SAT_FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic s; logic [31:0] w; } ent_t;
    ent_t        pend[$];
    logic [31:0] fq[$];
    bit          msat = 1'b0;
    bit          prev_clr = 1'b0;
    bit          mvalid = 1'b0;
    bit          m_clr;
    bit          m_full_pre;
    ent_t        m_e;
    int          m_n;
    logic [39:0] m_ln[5];

    function automatic ent_t model_sat(input logic [39:0] a);
        longint v;
        v = $signed(a);
`ifdef RESULT_OUT_RELU_EN
        if (v < 64'sd0) v = 64'sd0;
`endif
        if (v > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        else if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else return {1'b0, v[31:0]};
    endfunction

    always @(posedge CLK) begin
        if (!RESETN) begin
            pend.delete(); fq.delete(); msat = 1'b0; prev_clr = 1'b0; mvalid = 1'b1;
        end else begin
            m_clr = CLEAR_FIFO && !prev_clr;
            prev_clr = CLEAR_FIFO;
            if (m_clr) begin
                pend.delete(); fq.delete(); msat = 1'b0;
            end else begin
                m_full_pre = (fq.size() >= DEPTH);
                if (FIFO_RD_CMD && fq.size() > 0) void'(fq.pop_front());
                if (pend.size() > 0) begin
                    if (!m_full_pre) begin
                        m_e = pend.pop_front();
                        fq.push_back(m_e.w);
                        if (m_e.s) msat = 1'b1;
                    end
                end else if (RES_VALID) begin
                    m_ln[0] = RES_DATA_0; m_ln[1] = RES_DATA_1; m_ln[2] = RES_DATA_2;
                    m_ln[3] = RES_DATA_3; m_ln[4] = RES_DATA_4;
                    m_n = (PARAM_LANES == 3'd0) ? 1 : ((PARAM_LANES > 3'd5) ? 5 : int'(PARAM_LANES));
                    for (int i = 0; i < m_n; i++) pend.push_back(model_sat(m_ln[i]));
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (mvalid) begin
            chk1("m_ready", RES_READY, (pend.size() == 0) && !(RESETN && CLEAR_FIFO && !prev_clr));
            chk1("m_busy", BUSY, pend.size() != 0);
            chk1("m_empty", FIFO_EMPTY, fq.size() == 0);
            chk1("m_full", FIFO_FULL, fq.size() == DEPTH);
            chk1("m_sat", SAT_FLAG, msat);
            if (fq.size() > 0) chk("m_head", FIFO_RD_DATA, fq[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lanes(input logic [2:0] pl, input logic [39:0] a, input logic [39:0] b,
                             input logic [39:0] c, input logic [39:0] d, input logic [39:0] e);
        PARAM_LANES = pl;
        RES_DATA_0 = a; RES_DATA_1 = b; RES_DATA_2 = c; RES_DATA_3 = d; RES_DATA_4 = e;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!RES_READY && g < 200) begin tick(); g++; end
        if (g >= 200) chk("ready_timeout", 32'(g), 32'd0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (BUSY && g < 200) begin tick(); g++; end
        if (g >= 200) chk("idle_timeout", 32'(g), 32'd0);
    endtask

    task automatic send_set(input logic [2:0] pl, input logic [39:0] a, input logic [39:0] b,
                            input logic [39:0] c, input logic [39:0] d, input logic [39:0] e);
        set_lanes(pl, a, b, c, d, e);
        RES_VALID = 1'b1;
        wait_ready();
        tick();
        RES_VALID = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [31:0] exp);
        int g = 0;
        while (FIFO_EMPTY && g < 200) begin tick(); g++; end
        if (g >= 200) chk("pop_timeout", 32'(g), 32'd0);
        chk(nm, FIFO_RD_DATA, exp);
        FIFO_RD_CMD = 1'b1;
        tick();
        FIFO_RD_CMD = 1'b0;
    endtask

    task automatic clear_pulse();
        CLEAR_FIFO = 1'b1;
        tick(); tick();
        CLEAR_FIFO = 1'b0;
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        repeat (3) tick();
        RESETN = 1'b1;
        // reset state
        chk1("rst_ready", RES_READY, 1'b1);
        chk1("rst_busy", BUSY, 1'b0);
        chk1("rst_empty", FIFO_EMPTY, 1'b1);
        chk1("rst_full", FIFO_FULL, 1'b0);
        chk1("rst_sat", SAT_FLAG, 1'b0);
        tick();

        // basic drain
        send_set(3'd5, 40'd1, 40'd2, 40'd3, 40'd4, 40'd5);
        cnt = 0;
        while (!RES_READY && cnt < 20) begin cnt++; tick(); end
        chk("ready_low_cycles", 32'(cnt), 32'd5);
        chk1("basic_sat", SAT_FLAG, 1'b0);
        for (int i = 1; i <= 5; i++) pop_expect("basic_pop", 32'(i));
        chk1("basic_empty", FIFO_EMPTY, 1'b1);

        // partial lane counts
        send_set(3'd3, 40'd10, 40'd20, 40'd30, 40'd40, 40'd50);
        wait_idle();
        pop_expect("part3_a", 32'd10);
        pop_expect("part3_b", 32'd20);
        pop_expect("part3_c", 32'd30);
        chk1("part3_empty", FIFO_EMPTY, 1'b1);
        send_set(3'd0, 40'd99, 40'd98, 40'd97, 40'd96, 40'd95);
        wait_idle();
        pop_expect("part0", 32'd99);
        chk1("part0_empty", FIFO_EMPTY, 1'b1);
        send_set(3'd7, 40'd61, 40'd62, 40'd63, 40'd64, 40'd65);
        wait_idle();
        for (int i = 0; i < 5; i++) pop_expect("part7_pop", 32'(61 + i));
        chk1("part7_empty", FIFO_EMPTY, 1'b1);

        // exact limits pass through unclamped
        send_set(3'd2, 40'h00_7FFF_FFFF, 40'hFF_8000_0000, 40'd0, 40'd0, 40'd0);
        wait_idle();
        chk1("limit_nosat", SAT_FLAG, 1'b0);
`ifdef RESULT_OUT_RELU_EN
        pop_expect("limit_max", 32'h7FFF_FFFF);
        pop_expect("limit_min", 32'h0000_0000);
`else
        pop_expect("limit_max", 32'h7FFF_FFFF);
        pop_expect("limit_min", 32'h8000_0000);
`endif

        // saturation (words left in the FIFO for the clear test)
        send_set(3'd5, 40'h01_0000_0000, 40'hFF_0000_0000, 40'hFF_FFFF_FFF9,
                 40'h00_8000_0000, 40'hFF_7FFF_FFFF);
        wait_idle();
        chk1("sat_flag", SAT_FLAG, 1'b1);
        chk1("sat_nonempty", FIFO_EMPTY, 1'b0);

        // clear mid-drain with RES_VALID held
        set_lanes(3'd5, 40'd1, 40'd2, 40'd3, 40'd4, 40'd5);
        RES_VALID = 1'b1;
        wait_ready();
        tick();
        tick(); tick();
        CLEAR_FIFO = 1'b1;
        chk1("clr_ready_low", RES_READY, 1'b0);
        tick();
        chk1("clr_empty", FIFO_EMPTY, 1'b1);
        chk1("clr_sat", SAT_FLAG, 1'b0);
        chk1("clr_busy", BUSY, 1'b0);
        chk1("clr_ready_back", RES_READY, 1'b1);
        tick();
        chk1("clr_reaccept", BUSY, 1'b1);
        RES_VALID = 1'b0;
        tick();
        CLEAR_FIFO = 1'b0;
        wait_idle();
        for (int i = 1; i <= 5; i++) pop_expect("clr_pop", 32'(i));

        // saturation words re-checked as literals
        clear_pulse();
        send_set(3'd3, 40'h01_0000_0000, 40'hFF_0000_0000, 40'hFF_FFFF_FFF9, 40'd0, 40'd0);
        wait_idle();
        chk1("sat3_flag", SAT_FLAG, 1'b1);
`ifdef RESULT_OUT_RELU_EN
        pop_expect("sat3_a", 32'h7FFF_FFFF);
        pop_expect("sat3_b", 32'h0000_0000);
        pop_expect("sat3_c", 32'h0000_0000);
        clear_pulse();
        send_set(3'd3, 40'hFF_FFFF_FFFB, 40'd7, 40'hFF_0000_0000, 40'd0, 40'd0);
        wait_idle();
        chk1("relu_sat", SAT_FLAG, 1'b0);
        pop_expect("relu_a", 32'd0);
        pop_expect("relu_b", 32'd7);
        pop_expect("relu_c", 32'd0);
`else
        pop_expect("sat3_a", 32'h7FFF_FFFF);
        pop_expect("sat3_b", 32'h8000_0000);
        pop_expect("sat3_c", 32'hFFFF_FFF9);
`endif

        // full stall: 20 words into a 16-deep FIFO with no reads
        for (int k = 0; k < 4; k++) begin
            send_set(3'd5, 40'(100 + 5 * k), 40'(101 + 5 * k), 40'(102 + 5 * k),
                     40'(103 + 5 * k), 40'(104 + 5 * k));
        end
        repeat (8) tick();
        chk1("stall_busy", BUSY, 1'b1);
        chk1("stall_full", FIFO_FULL, 1'b1);
        for (int i = 0; i < 4; i++) pop_expect("stall_pop", 32'(100 + i));
        wait_idle();
        for (int i = 4; i < 20; i++) pop_expect("stall_rest", 32'(100 + i));
        chk1("stall_empty", FIFO_EMPTY, 1'b1);

        // pop while empty is ignored
        FIFO_RD_CMD = 1'b1;
        tick(); tick();
        FIFO_RD_CMD = 1'b0;
        chk1("empty_pop", FIFO_EMPTY, 1'b1);

        // reset mid-drain
        send_set(3'd5, 40'd7, 40'd8, 40'd9, 40'd10, 40'd11);
        tick(); tick();
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        chk1("rstmid_empty", FIFO_EMPTY, 1'b1);
        chk1("rstmid_busy", BUSY, 1'b0);
        chk1("rstmid_ready", RES_READY, 1'b1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
